// File: rtl/fat32_pkg.sv
// Shared FAT32 constants, state encoding and sizing helper for the FAT sector streamer.
package fat32_pkg;

    localparam logic [31:0] FAT32_EOC        = 32'h0FFFFFFF;
    localparam logic [31:0] FAT32_MEDIA      = 32'h0FFFFFF8;
    localparam logic [31:0] FAT32_FREE       = 32'h00000000;
    localparam logic [31:0] FAT32_ENTRY_MASK = 32'h0FFFFFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int fat32_entries_per_sector(input int sector_bytes);
        return sector_bytes / 4;
    endfunction

endpackage

// File: rtl/fat32_entry_resolve.sv
// Combinational FAT32 entry lookup: reserved entries, then lowest-index matching chain.
// The multi-match flag is only built when FAT_OVERLAP_CHECK_EN is defined; otherwise it is 0.
module fat32_entry_resolve
    import fat32_pkg::*;
#(
    parameter int NUM_CHAINS = 2
) (
    input  logic [31:0]              n,
    input  logic [32*NUM_CHAINS-1:0] chain_first,
    input  logic [32*NUM_CHAINS-1:0] chain_count,
    output logic [31:0]              value,
    output logic                     multi
);

    logic [32:0]           n33;
    logic [NUM_CHAINS-1:0] hit;
    logic [NUM_CHAINS-1:0] at_end;
    logic                  found;

    assign n33 = {1'b0, n};

    // 33-bit bounds so a chain reaching past 2^32-1 never wraps back to low entries.
    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        logic [32:0] lo;
        logic [32:0] hi;
        assign lo        = {1'b0, chain_first[32*c +: 32]};
        assign hi        = lo + {1'b0, chain_count[32*c +: 32]} - 33'd1;
        assign hit[c]    = (chain_count[32*c +: 32] != 32'd0) && (n33 >= lo) && (n33 <= hi);
        assign at_end[c] = (n33 == hi);
    end

    always_comb begin
        value = FAT32_FREE;
        found = 1'b0;
        if (n == 32'd0) begin
            value = FAT32_MEDIA;
        end else if (n == 32'd1) begin
            value = FAT32_EOC;
        end else begin
            for (int c = 0; c < NUM_CHAINS; c++) begin
                if (hit[c] && !found) begin
                    found = 1'b1;
                    value = at_end[c] ? FAT32_EOC : ((n + 32'd1) & FAT32_ENTRY_MASK);
                end
            end
        end
    end

`ifdef FAT_OVERLAP_CHECK_EN
    logic seen;
    always_comb begin
        multi = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            if (hit[c]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        if (n < 32'd2) multi = 1'b0;
    end
`else
    assign multi = 1'b0;
`endif

endmodule

// File: rtl/fat32_chain_streamer.sv
// Streams one FAT32 table sector for NUM_CHAINS contiguous chains, one byte per accepted beat.
// Latency: first byte valid from the start edge; 512 beats then a one-cycle done; holds on !out_ready.
// Optional FAT_OVERLAP_CHECK_EN builds the sticky overlap_err detector; default build ties it to 0.
module fat32_chain_streamer
    import fat32_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 9,
    parameter int NUM_CHAINS   = 2
) (
    input  logic                     Clock,
    input  logic                     sys_rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              fat_sector_index,
    input  logic [32*NUM_CHAINS-1:0] chain_first,
    input  logic [32*NUM_CHAINS-1:0] chain_count,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic                     done,
    output logic                     overlap_err
);

    localparam int                KW        = ADDR_W - 2;
    localparam logic [31:0]       EPS       = 32'(fat32_entries_per_sector(SECTOR_BYTES));
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SECTOR_BYTES - 1);

    logic [1:0]               state_q;
    logic [31:0]              idx_q;
    logic [32*NUM_CHAINS-1:0] first_q;
    logic [32*NUM_CHAINS-1:0] count_q;
    logic [31:0]              entry_q;
    logic [ADDR_W-1:0]        addr_q;

    logic                     in_idle;
    logic                     hs;
    logic                     word_end;
    logic [KW-1:0]            slot;
    logic [31:0]              res_n;
    logic [32*NUM_CHAINS-1:0] res_first;
    logic [32*NUM_CHAINS-1:0] res_count;
    logic [31:0]              res_value;
    logic                     res_multi;

    assign in_idle   = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_EMIT);
    assign busy      = !in_idle;
    assign done      = (state_q == ST_DONE);
    assign out_addr  = addr_q;
    assign out_last  = out_valid && (addr_q == LAST_ADDR);
    assign out_byte  = out_valid ? entry_q[{addr_q[1:0], 3'b000} +: 8] : 8'h00;
    assign hs        = out_valid && out_ready;
    assign word_end  = (addr_q[1:0] == 2'b11);
    assign slot      = addr_q[ADDR_W-1:2];

    // In IDLE the resolver sees the live inputs so entry 0 can be loaded on the start edge;
    // while emitting it looks one entry ahead of the byte currently on the bus.
    always_comb begin
        res_first = first_q;
        res_count = count_q;
        res_n     = idx_q * EPS + {{(32-KW){1'b0}}, slot} + 32'd1;
        if (in_idle) begin
            res_first = chain_first;
            res_count = chain_count;
            res_n     = fat_sector_index * EPS;
        end
    end

    fat32_entry_resolve #(
        .NUM_CHAINS (NUM_CHAINS)
    ) u_resolve (
        .n           (res_n),
        .chain_first (res_first),
        .chain_count (res_count),
        .value       (res_value),
        .multi       (res_multi)
    );

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            count_q <= '0;
            entry_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_EMIT;
                        idx_q   <= fat_sector_index;
                        first_q <= chain_first;
                        count_q <= chain_count;
                        entry_q <= res_value;
                        addr_q  <= '0;
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        addr_q  <= '0;
                    end else if (hs) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (out_last) begin
                            state_q <= ST_DONE;
                        end else if (word_end) begin
                            entry_q <= res_value;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FAT_OVERLAP_CHECK_EN
    logic err_q;
    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
        end else if (in_idle && start) begin
            err_q <= res_multi;
        end else if (hs && !abort && word_end && !out_last && res_multi) begin
            err_q <= 1'b1;
        end
    end
    assign overlap_err = err_q;
`else
    // The resolver drives a constant 0 here when the overlap check is compiled out.
    assign overlap_err = res_multi;
`endif

endmodule

// File: tb/tb_fat32_chain_streamer.sv
// Directed bench for fat32_chain_streamer: scoreboard of expected beats plus literal checks.
module tb_fat32_chain_streamer;

    localparam int SB = 512;
    localparam int AW = 9;
    localparam int NC = 2;

`ifdef FAT_OVERLAP_CHECK_EN
    localparam logic EXP_OVL = 1'b1;
`else
    localparam logic EXP_OVL = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   fat_sector_index = '0;
    logic [63:0]   chain_first = '0;
    logic [63:0]   chain_count = '0;
    logic          busy;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          done;
    logic          overlap_err;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [16:0]   sb_q[$];
    logic [7:0]    cap [SB];

    always #5 Clock = ~Clock;

    fat32_chain_streamer #(
        .SECTOR_BYTES (SB),
        .ADDR_W       (AW),
        .NUM_CHAINS   (NC)
    ) dut (
        .Clock            (Clock),
        .sys_rst_n        (sys_rst_n),
        .start            (start),
        .abort            (abort),
        .fat_sector_index (fat_sector_index),
        .chain_first      (chain_first),
        .chain_count      (chain_count),
        .busy             (busy),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_byte         (out_byte),
        .out_addr         (out_addr),
        .out_last         (out_last),
        .done             (done),
        .overlap_err      (overlap_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_entry(input logic [31:0] n, input logic [31:0] f0,
                                                input logic [31:0] c0, input logic [31:0] f1,
                                                input logic [31:0] c1);
        logic [31:0] f [2];
        logic [31:0] c [2];
        logic [63:0] off;
        f[0] = f0; f[1] = f1; c[0] = c0; c[1] = c1;
        if (n == 32'd0) return 32'h0FFFFFF8;
        if (n == 32'd1) return 32'h0FFFFFFF;
        for (int i = 0; i < 2; i++) begin
            if (c[i] != 0 && n >= f[i]) begin
                off = {32'd0, n} - {32'd0, f[i]};
                if (off < {32'd0, c[i]})
                    return (off == {32'd0, c[i]} - 64'd1) ? 32'h0FFFFFFF : ((n + 32'd1) & 32'h0FFFFFFF);
            end
        end
        return 32'h0;
    endfunction

    // Consumer side: every beat that will be accepted at the next edge is popped and compared.
    always @(negedge Clock) begin : mon
        logic [16:0] e;
        if (sys_rst_n && !abort && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("beat_addr", 32'(out_addr), 32'(e[16:8]));
                check("beat_byte", 32'(out_byte), 32'(e[7:0]));
                check("beat_last", 32'(out_last), 32'(out_addr == AW'(SB - 1)));
            end
            cap[out_addr] = out_byte;
        end
    end

    task automatic set_cfg(input logic [31:0] idx, input logic [31:0] f0, input logic [31:0] c0,
                           input logic [31:0] f1, input logic [31:0] c1);
        fat_sector_index = idx;
        chain_first      = {f1, f0};
        chain_count      = {c1, c0};
    endtask

    task automatic load_expect();
        logic [31:0] v;
        for (int k = 0; k < SB / 4; k++) begin
            v = model_entry(fat_sector_index * 32'd128 + 32'(k), chain_first[31:0],
                            chain_count[31:0], chain_first[63:32], chain_count[63:32]);
            for (int b = 0; b < 4; b++) sb_q.push_back({9'(4 * k + b), v[8*b +: 8]});
        end
    endtask

    task automatic do_start(output time t0);
        @(posedge Clock); #1 start = 1'b1;
        @(posedge Clock); t0 = $time; #1 start = 1'b0;
    endtask

    task automatic wait_done(input time t0, output int cyc);
        int guard;
        guard = 0;
        while (!done && guard < 700) begin
            @(posedge Clock); #1;
            guard++;
        end
        check("done_seen", 32'(done), 32'd1);
        cyc = int'(($time - 1 - t0) / 10);
    endtask

    task automatic wait_addr(input int a);
        int guard;
        guard = 0;
        while (!(out_valid && out_addr == AW'(a)) && guard < 700) begin
            @(posedge Clock); #1;
            guard++;
        end
        check("addr_reached", 32'(out_addr), 32'(a));
    endtask

    initial begin : main
        time         t0;
        int          cyc;
        logic [7:0]  hold_b;
        logic [7:0]  exp0 [32];
        exp0 = '{8'hF8, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h0F,
                 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
                 8'h07, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h0F};

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_byte", 32'(out_byte), 32'd0);
        check("rst_last_done_ovl", {29'd0, out_last, done, overlap_err}, 32'd0);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;

        // Sector 0, two chains; inputs scrambled after start must not matter
        set_cfg(32'd0, 32'd2, 32'd1, 32'd5, 32'd3);
        load_expect();
        do_start(t0);
        check("s0_first_valid", 32'(out_valid), 32'd1);
        check("s0_first_addr", 32'(out_addr), 32'd0);
        check("s0_first_byte", 32'(out_byte), 32'hF8);
        set_cfg(32'd7, 32'hFFFFFFFF, 32'd9, 32'd0, 32'd0);
        wait_done(t0, cyc);
        check("s0_done_cycle", 32'(cyc), 32'd512);
        check("s0_busy_in_done", 32'(busy), 32'd1);
        @(posedge Clock); #1;
        check("s0_done_pulse", 32'(done), 32'd0);
        check("s0_busy_low", 32'(busy), 32'd0);
        check("s0_sb_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 32; i++) check("s0_lit", {16'(i), 8'd0, cap[i]}, {16'(i), 8'd0, exp0[i]});
        for (int i = 32; i < SB; i++) check("s0_zero", {16'(i), 8'd0, cap[i]}, {16'(i), 16'd0});

        // Sector 1 with a 3-cycle stall at address 20
        set_cfg(32'd1, 32'd100, 32'd200, 32'd0, 32'd0);
        load_expect();
        do_start(t0);
        wait_addr(20);
        out_ready = 1'b0;
        hold_b    = out_byte;
        repeat (3) begin
            @(posedge Clock); #1;
            check("stall_addr", 32'(out_addr), 32'd20);
            check("stall_byte", 32'(out_byte), 32'(hold_b));
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_done(t0, cyc);
        check("s1_done_cycle", 32'(cyc), 32'd515);
        check("s1_sb_empty", 32'(sb_q.size()), 32'd0);
        check("s1_e128", {cap[3], cap[2], cap[1], cap[0]}, 32'h00000081);
        check("s1_e255", {cap[511], cap[510], cap[509], cap[508]}, 32'h00000100);

        // Overlapping chains: chain0 wins, sticky flag depends on build
        @(posedge Clock); #1;
        set_cfg(32'd0, 32'd10, 32'd5, 32'd12, 32'd2);
        load_expect();
        do_start(t0);
        wait_done(t0, cyc);
        check("ovl_e12", {cap[51], cap[50], cap[49], cap[48]}, 32'h0000000D);
        check("ovl_flag", 32'(overlap_err), 32'(EXP_OVL));
        @(posedge Clock); #1;
        check("ovl_sticky", 32'(overlap_err), 32'(EXP_OVL));
        set_cfg(32'd5, 32'd10, 32'd5, 32'd12, 32'd2);
        load_expect();
        do_start(t0);
        check("ovl_cleared", 32'(overlap_err), 32'd0);
        wait_done(t0, cyc);
        check("s5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-sector, then a clean restart
        @(posedge Clock); #1;
        set_cfg(32'd0, 32'd2, 32'd1, 32'd5, 32'd3);
        load_expect();
        do_start(t0);
        wait_addr(100);
        sys_rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_addr", 32'(out_addr), 32'd0);
        check("mrst_byte", 32'(out_byte), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge Clock);
        #2 sys_rst_n = 1'b1;
        load_expect();
        do_start(t0);
        check("rs_addr", 32'(out_addr), 32'd0);
        check("rs_byte", 32'(out_byte), 32'hF8);
        wait_done(t0, cyc);
        check("rs_done_cycle", 32'(cyc), 32'd512);
        check("rs_sb_empty", 32'(sb_q.size()), 32'd0);

        // Start while busy is ignored; abort returns to IDLE with no done
        @(posedge Clock); #1;
        set_cfg(32'd2, 32'd300, 32'd100, 32'd0, 32'd0);
        load_expect();
        do_start(t0);
        wait_addr(50);
        start = 1'b1;
        @(posedge Clock); #1 start = 1'b0;
        check("ign_start_addr", 32'(out_addr), 32'd51);
        check("ign_start_busy", 32'(busy), 32'd1);
        wait_addr(60);
        abort = 1'b1;
        @(posedge Clock); #1 abort = 1'b0;
        sb_q.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            @(posedge Clock); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fat32_chain_streamer.md
# fat32_chain_streamer

Generates one 512-byte FAT32 allocation-table sector as a byte stream for up to `NUM_CHAINS` contiguous cluster chains, with entries 0/1 reserved, on demand for any FAT sector index. It generalises the fixed single-file FAT sector generator to multiple chains, arbitrary sector index, valid/ready backpressure and registered configuration capture. It sits between the file-system bookkeeping logic and the SD block-write path, which consumes one byte per accepted beat.

## Interface
- `SECTOR_BYTES`, 512, bytes per sector; must be a multiple of 4.
- `ADDR_W`, 9, byte-address width, log2(SECTOR_BYTES).
- `NUM_CHAINS`, 2, number of independent contiguous chains; minimum 1.
- `Clock`  in  1  system clock, rising edge.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request one sector; accepted only in IDLE.
- `abort`  in  1  synchronous; drops the current sector, returns to IDLE, no `done`.
- `fat_sector_index`  in  32  sector number relative to FAT start.
- `chain_first`  in  32*NUM_CHAINS  first cluster of each chain; chain c occupies bits [32c+31:32c].
- `chain_count`  in  32*NUM_CHAINS  cluster count of each chain; 0 disables the chain.
- `busy`  out  1  high outside IDLE.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  consumer accepts the byte.
- `out_byte`  out  8  FAT byte, little-endian within each entry.
- `out_addr`  out  ADDR_W  byte offset within the sector.
- `out_last`  out  1  marks the beat with `out_addr` = SECTOR_BYTES-1.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `overlap_err`  out  1  sticky; present only with the configuration macro (see Configuration).

## Operation
- States: IDLE, EMIT, DONE.
- IDLE → EMIT on `start`.
  - Captures `fat_sector_index`, `chain_first` and `chain_count` into registers at that edge.
  - Later input changes have no effect until the next `start`.
- Entry index: n = fat_sector_index*(SECTOR_BYTES/4) + k, computed mod 2^32, where k is the entry slot in the sector.
- Entry value, first match wins:
  - n = 0 → 0x0FFFFFF8.
  - n = 1 → 0x0FFFFFFF.
  - Else, take the lowest-index chain c with count ≥ 1 and first ≤ n ≤ first+count−1. Compare in 33 bits, with no wrap.
    - n < first+count−1 → n+1, with bits [31:28] forced to 0.
    - n = first+count−1 → 0x0FFFFFFF.
  - No chain matches → 0x00000000.
- Entry register:
  - Loaded with the value of entry k=0 at `start`.
  - Reloaded with the value of entry k+1 on the handshake of byte 3 of entry k, so there are no bubbles between entries.
- `out_byte` = entry[8*out_addr[1:0] +: 8].
- `out_addr` advances by 1 only on a handshake (`out_valid` && `out_ready`).
- On the handshake where `out_last` is high: EMIT → DONE. DONE lasts one cycle, asserts `done`, then goes to IDLE.
- `abort` in EMIT or DONE → IDLE next edge; `done` is not pulsed. `abort` has priority over a handshake in the same cycle.
- `start` while busy is ignored.

## Timing
- Reset values (asynchronous): state IDLE; `busy`, `out_valid`, `out_last`, `done`, `overlap_err` = 0; `out_byte` = 0; `out_addr` = 0; captured registers = 0.
- Latency:
  - `start` sampled at edge T → `out_valid` = 1, `out_addr` = 0 and a valid `out_byte` from edge T onward.
  - With `out_ready` held high, one byte per cycle; last beat at T+511; `done` high in cycle T+512; `busy` low from T+513.
  - Back-to-back: `start` is accepted again at edge T+513.
- While `out_valid` && !`out_ready`, `out_byte`, `out_addr` and `out_last` hold stable.
- `out_valid` never drops in EMIT.
- Reset asserted mid-sector clears all outputs immediately. The next `start` begins at address 0.

## Configuration
- `FAT_OVERLAP_CHECK_EN` defined:
  - `overlap_err` is set when any emitted entry n ≥ 2 matches more than one enabled chain.
  - It clears only on the next accepted `start` or on reset.
  - The emitted value still follows lowest-index priority.
- Not defined: `overlap_err` is tied to 0 and no overlap comparators are built.

## Structure
- Package `fat32_pkg`:
  - `FAT32_EOC` = 32'h0FFFFFFF.
  - `FAT32_MEDIA` = 32'h0FFFFFF8.
  - `FAT32_FREE` = 32'h0.
  - `FAT32_ENTRY_MASK` = 32'h0FFFFFFF.
  - Entries-per-sector function.
  - State encoding.
- Sub-module `fat32_entry_resolve`: combinational. Takes entry index n and the captured chain arrays; returns the entry value and a multi-match flag. It is instantiated once, for entry k+1 (or k=0 at `start`).

## Test plan
- Sector 0; chain0 first=2, count=1; chain1 first=5, count=3; `out_ready`=1 → expected bytes:
  - Addresses 0–3 = F8 FF FF 0F; 4–7 = FF FF FF 0F; 8–11 = FF FF FF 0F.
  - Entry 5 = 06 00 00 00; entry 6 = 07 00 00 00; entry 7 = FF FF FF 0F.
  - All other bytes 00.
  - `done` pulses in cycle T+512.
- Sector 1; chain0 first=100, count=200 → entry 128 = 81 00 00 00, entry 255 = 00 01 00 00. No EOC appears, since the chain ends at 299.
- `out_ready` low for 3 cycles while `out_addr`=20 → `out_byte` and `out_addr` unchanged for those 3 cycles. Total completion is 3 cycles later, with no bytes lost or duplicated.
- Chain0 first=10, count=5; chain1 first=12, count=2:
  - Entry 12 = 0D 00 00 00 (chain0 wins).
  - `overlap_err`=1 with `FAT_OVERLAP_CHECK_EN`; stays 0 without it.
- Reset asserted at `out_addr`=100 → all outputs 0 immediately. Next `start` streams again from address 0 with correct data.
- `start` pulsed at `out_addr`=50 → ignored, the stream continues. `abort` at `out_addr`=60 → IDLE next cycle, with no `done`.
